// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of the 5-stage RV32I pipeline, upstream of IF/ID.
//   Generates the fetch PC, issues in-order requests to a variable-latency
//   instruction memory, pairs each returned word with its PC through a tag
//   queue, buffers the pairs and presents the oldest one to IF/ID.
//
// Ports
//   clk, reset_n     clock (posedge) and asynchronous active-low reset
//   stall            IF/ID is holding; the presented instruction is not taken
//   redirect         taken branch/jump from EX; flushes the whole fetch path
//   redirect_pc      new fetch target (low two bits ignored)
//   imem_req_*       request channel (valid/ready, word-aligned address)
//   imem_rsp_*       in-order response channel (valid, instruction word)
//   instr_o/pc_o     buffered instruction and its PC (NOP / 0 when empty)
//   valid_o          instr_o/pc_o carry a real fetched instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CWP = CW + 1;

    localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;
    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   DEPTH_W   = CWP'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_r;
    logic [31:0]   fetch_pc_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;
    logic [CW-1:0] fifo_cnt_r;
    logic [PW-1:0] fifo_wp_r;
    logic [PW-1:0] fifo_rp_r;
    logic [PW-1:0] tag_wp_r;
    logic [PW-1:0] tag_rp_r;
    logic [31:0]   tag_r        [FIFO_DEPTH];
    logic [31:0]   fifo_pc_r    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_r [FIFO_DEPTH];

    logic [31:0]   redirect_target_s;
    logic          credit_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          rsp_fire_s;
    logic          drop_s;
    logic          fifo_push_s;
    logic          fifo_pop_s;
    logic          fifo_full_s;
    logic          valid_s;
    logic [CW-1:0] outstanding_nxt_s;
    logic [CW-1:0] discard_nxt_s;

    // Handshake decode, credit check and next-count computation
    always_comb begin
        redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
        // In-flight plus buffered words may never exceed the buffer size, so
        // every response always has a free slot waiting for it.
        credit_s    = ({1'b0, outstanding_r} + {1'b0, fifo_cnt_r}) < DEPTH_W;
        req_valid_s = (state_r != ST_IDLE) && !redirect && credit_s;
        req_fire_s  = req_valid_s && imem_req_ready;
        // A response with nothing outstanding is a stray and is ignored.
        rsp_fire_s  = imem_rsp_valid && (outstanding_r != CNT_ZERO);
        drop_s      = rsp_fire_s && (discard_r != CNT_ZERO);
        fifo_push_s = rsp_fire_s && (discard_r == CNT_ZERO) && !redirect;
        valid_s     = (fifo_cnt_r != CNT_ZERO);
        fifo_pop_s  = valid_s && !stall && !redirect;
        fifo_full_s = (fifo_cnt_r == DEPTH_C);
        outstanding_nxt_s = outstanding_r
                          + (req_fire_s ? CNT_ONE : CNT_ZERO)
                          - (rsp_fire_s ? CNT_ONE : CNT_ZERO);
        // On redirect every word still in flight belongs to the old path;
        // one arriving in the same cycle is dropped right away.
        if (redirect) begin
            discard_nxt_s = outstanding_r - (rsp_fire_s ? CNT_ONE : CNT_ZERO);
        end else if (drop_s) begin
            discard_nxt_s = discard_r - CNT_ONE;
        end else begin
            discard_nxt_s = discard_r;
        end
    end

    // Control state: FSM, fetch PC, in-flight/discard counters, queue pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= CNT_ZERO;
            discard_r     <= CNT_ZERO;
            fifo_cnt_r    <= CNT_ZERO;
            fifo_wp_r     <= PTR_ZERO;
            fifo_rp_r     <= PTR_ZERO;
            tag_wp_r      <= PTR_ZERO;
            tag_rp_r      <= PTR_ZERO;
        end else begin
            case (state_r)
                ST_IDLE:  state_r <= ST_RUN;
                ST_RUN,
                ST_DRAIN: state_r <= (discard_nxt_s != CNT_ZERO) ? ST_DRAIN : ST_RUN;
                default:  state_r <= ST_IDLE;
            endcase

            if (redirect) begin
                fetch_pc_r <= redirect_target_s;
            end else if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end

            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;

            if (redirect) begin
                fifo_cnt_r <= CNT_ZERO;
                fifo_wp_r  <= PTR_ZERO;
                fifo_rp_r  <= PTR_ZERO;
                tag_wp_r   <= PTR_ZERO;
                tag_rp_r   <= PTR_ZERO;
            end else begin
                if (req_fire_s) begin
                    tag_wp_r <= tag_wp_r + PTR_ONE;
                end
                if (fifo_push_s) begin
                    tag_rp_r  <= tag_rp_r + PTR_ONE;
                    fifo_wp_r <= fifo_wp_r + PTR_ONE;
                end
                if (fifo_pop_s) begin
                    fifo_rp_r <= fifo_rp_r + PTR_ONE;
                end
                case ({fifo_push_s, fifo_pop_s})
                    2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
                    2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
                    default: fifo_cnt_r <= fifo_cnt_r;
                endcase
            end
        end
    end

    // Data storage for PC tags and returned instruction/PC pairs (no reset needed)
    always_ff @(posedge clk) begin
        if (req_fire_s) begin
            tag_r[tag_wp_r] <= fetch_pc_r;
        end
        if (fifo_push_s) begin
            fifo_pc_r[fifo_wp_r]    <= tag_r[tag_rp_r];
            fifo_instr_r[fifo_wp_r] <= imem_rsp_data;
        end
    end

    // Output drive: buffer head, or a NOP bubble when the buffer is empty
    always_comb begin
        imem_req_valid = req_valid_s;
        imem_req_addr  = fetch_pc_r;
        valid_o        = valid_s;
        if (valid_s) begin
            instr_o = fifo_instr_r[fifo_rp_r];
            pc_o    = fifo_pc_r[fifo_rp_r];
        end else begin
            instr_o = NOP_INSTR;
            pc_o    = 32'h0000_0000;
        end
    end

    // The credit rule must keep the instruction buffer from ever overflowing.
    a_fifo_no_overflow: assert property (
        @(posedge clk) disable iff (!reset_n)
        !(fifo_push_s && !fifo_pop_s && fifo_full_s)
    );

endmodule
